// File: rtl/pipe_stage_chain_if.sv
// Bundle for the pipe_stage_chain entry stream, control inputs, last-stage outputs and taps.
// The producer/observer side uses master; the chain itself uses slave.
interface pipe_stage_chain_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5,
   parameter int DEPTH  = 2,
   parameter int CNT_W  = 4
);
   logic                    stall;
   logic                    flush;
   logic                    in_valid;
   logic                    RegWrite_in;
   logic [ADDR_W-1:0]       RdAddr_in;
   logic [DATA_W-1:0]       ALU_result_in;
   logic                    out_valid;
   logic                    RegWrite_out;
   logic [ADDR_W-1:0]       RdAddr_out;
   logic [DATA_W-1:0]       ALU_result_out;
   logic [DEPTH-1:0]        tap_wr;
   logic [DEPTH*ADDR_W-1:0] tap_rd;
   logic [CNT_W-1:0]        occupancy;

   modport master (
      output stall, flush, in_valid, RegWrite_in, RdAddr_in, ALU_result_in,
      input  out_valid, RegWrite_out, RdAddr_out, ALU_result_out, tap_wr, tap_rd, occupancy
   );

   modport slave (
      input  stall, flush, in_valid, RegWrite_in, RdAddr_in, ALU_result_in,
      output out_valid, RegWrite_out, RdAddr_out, ALU_result_out, tap_wr, tap_rd, occupancy
   );
endinterface

// File: rtl/pipe_stage_chain.sv
// DEPTH-stage chain carrying RegWrite, destination address and ALU result, with stall,
// flush, per-stage valid, $0 write suppression, hazard taps and a registered occupancy count.
module pipe_stage_chain #(
   parameter int DATA_W     = 32,
   parameter int ADDR_W     = 5,
   parameter int DEPTH      = 2,
   parameter int ZERO_GUARD = 1,
   parameter int CNT_W      = 4
) (
   input logic              clk,
   input logic              rst,
   pipe_stage_chain_if.slave bus
);

   logic [DEPTH-1:0]        valid_r;
   logic [DEPTH-1:0]        wr_r;
   logic [ADDR_W-1:0]       rd_r  [DEPTH];
   logic [DATA_W-1:0]       res_r [DEPTH];
   logic [CNT_W-1:0]        occ_r;

   logic [DEPTH-1:0]        valid_s;
   logic [DEPTH-1:0]        wr_s;
   logic [ADDR_W-1:0]       rd_s  [DEPTH];
   logic [DATA_W-1:0]       res_s [DEPTH];
   logic [CNT_W-1:0]        occ_s;
   logic                    zero_hit_s;
   logic                    wr_in_s;
   logic [DEPTH*ADDR_W-1:0] tap_rd_s;

   // Qualify the incoming write: bubbles and (optionally) $0 never write.
   always_comb begin
      zero_hit_s = (ZERO_GUARD != 0) && (bus.RdAddr_in == {ADDR_W{1'b0}});
      wr_in_s    = bus.RegWrite_in & bus.in_valid & ~zero_hit_s;
   end

   // Next-state of every stage: flush beats stall beats shift; rd/res survive a flush.
   always_comb begin
      valid_s = valid_r;
      wr_s    = wr_r;
      rd_s    = rd_r;
      res_s   = res_r;
      if (bus.flush) begin
         valid_s = {DEPTH{1'b0}};
         wr_s    = {DEPTH{1'b0}};
      end else if (bus.stall) begin
         valid_s = valid_r;
         wr_s    = wr_r;
      end else begin
         valid_s[0] = bus.in_valid;
         wr_s[0]    = wr_in_s;
         rd_s[0]    = bus.RdAddr_in;
         res_s[0]   = bus.ALU_result_in;
         for (int i = 1; i < DEPTH; i++) begin
            valid_s[i] = valid_r[i-1];
            wr_s[i]    = wr_r[i-1];
            rd_s[i]    = rd_r[i-1];
            res_s[i]   = res_r[i-1];
         end
      end
      occ_s = {CNT_W{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
         occ_s = occ_s + CNT_W'(valid_s[i]);
      end
   end

   // Stage registers and occupancy, synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         valid_r <= {DEPTH{1'b0}};
         wr_r    <= {DEPTH{1'b0}};
         occ_r   <= {CNT_W{1'b0}};
         for (int i = 0; i < DEPTH; i++) begin
            rd_r[i]  <= {ADDR_W{1'b0}};
            res_r[i] <= {DATA_W{1'b0}};
         end
      end else begin
         valid_r <= valid_s;
         wr_r    <= wr_s;
         occ_r   <= occ_s;
         for (int i = 0; i < DEPTH; i++) begin
            rd_r[i]  <= rd_s[i];
            res_r[i] <= res_s[i];
         end
      end
   end

   // Pack per-stage destination addresses for the hazard unit.
   always_comb begin
      tap_rd_s = {(DEPTH*ADDR_W){1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
         tap_rd_s[i*ADDR_W +: ADDR_W] = rd_r[i];
      end
   end

   assign bus.out_valid      = valid_r[DEPTH-1];
   assign bus.RegWrite_out   = wr_r[DEPTH-1];
   assign bus.RdAddr_out     = rd_r[DEPTH-1];
   assign bus.ALU_result_out = res_r[DEPTH-1];
   assign bus.tap_wr         = wr_r;
   assign bus.tap_rd         = tap_rd_s;
   assign bus.occupancy      = occ_r;

endmodule

// File: tb/tb_pipe_stage_chain.sv
// Drives three chain configurations (D2/guard, D2/no guard, D4/guard) with identical stimulus
// and scores them against a queue-of-entries reference model.
module tb_pipe_stage_chain;

   typedef struct packed {
      logic        v;
      logic        w;
      logic [4:0]  rd;
      logic [31:0] res;
   } ent_t;

   localparam int NDUT = 3;
   int dep_k [NDUT] = '{2, 2, 4};
   int zg_k  [NDUT] = '{1, 0, 1};

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic stall_s = 1'b0, flush_s = 1'b0, v_s = 1'b0, w_s = 1'b0;
   logic [4:0]  rd_s  = 5'd0;
   logic [31:0] res_s = 32'd0;

   int   errors = 0;
   int   checks = 0;
   bit   armed  = 1'b0;
   ent_t hist [NDUT][$];

   always #5 clk = ~clk;

   pipe_stage_chain_if #(.DATA_W(32), .ADDR_W(5), .DEPTH(2), .CNT_W(4)) bus0 ();
   pipe_stage_chain_if #(.DATA_W(32), .ADDR_W(5), .DEPTH(2), .CNT_W(4)) bus1 ();
   pipe_stage_chain_if #(.DATA_W(32), .ADDR_W(5), .DEPTH(4), .CNT_W(4)) bus2 ();

   assign bus0.stall = stall_s;  assign bus1.stall = stall_s;  assign bus2.stall = stall_s;
   assign bus0.flush = flush_s;  assign bus1.flush = flush_s;  assign bus2.flush = flush_s;
   assign bus0.in_valid = v_s;   assign bus1.in_valid = v_s;   assign bus2.in_valid = v_s;
   assign bus0.RegWrite_in = w_s; assign bus1.RegWrite_in = w_s; assign bus2.RegWrite_in = w_s;
   assign bus0.RdAddr_in = rd_s; assign bus1.RdAddr_in = rd_s; assign bus2.RdAddr_in = rd_s;
   assign bus0.ALU_result_in = res_s; assign bus1.ALU_result_in = res_s; assign bus2.ALU_result_in = res_s;

   pipe_stage_chain #(.DATA_W(32), .ADDR_W(5), .DEPTH(2), .ZERO_GUARD(1), .CNT_W(4))
      dut0 (.clk(clk), .rst(rst), .bus(bus0.slave));
   pipe_stage_chain #(.DATA_W(32), .ADDR_W(5), .DEPTH(2), .ZERO_GUARD(0), .CNT_W(4))
      dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));
   pipe_stage_chain #(.DATA_W(32), .ADDR_W(5), .DEPTH(4), .ZERO_GUARD(1), .CNT_W(4))
      dut2 (.clk(clk), .rst(rst), .bus(bus2.slave));

   task automatic check(input string name, input int k, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s dut%0d: got %0h expected %0h at %0t", name, k, got, exp, $time);
      end
   endtask

   // One clock edge: apply inputs, then record what that edge should have done.
   task automatic step(input logic r, input logic st, input logic fl, input logic v,
                       input logic w, input logic [4:0] rd, input logic [31:0] res);
      ent_t e;
      rst = r; stall_s = st; flush_s = fl; v_s = v; w_s = w; rd_s = rd; res_s = res;
      @(posedge clk);
      for (int k = 0; k < NDUT; k++) begin
         if (r) begin
            hist[k].delete();
         end else if (fl) begin
            for (int i = 0; i < hist[k].size(); i++) begin
               hist[k][i].v = 1'b0;
               hist[k][i].w = 1'b0;
            end
         end else if (!st) begin
            e.v   = v;
            e.w   = w & v & ~((zg_k[k] != 0) && (rd == 5'd0));
            e.rd  = rd;
            e.res = res;
            hist[k].push_front(e);
         end
      end
      if (r) armed = 1'b1;
      #1;
   endtask

   function automatic ent_t stage(input int k, input int i);
      ent_t z;
      z = '0;
      if (i < hist[k].size()) return hist[k][i];
      return z;
   endfunction

   task automatic score(input int k, input logic ov, input logic rw, input logic [4:0] ra,
                        input logic [31:0] ar, input logic [7:0] tw, input logic [39:0] tr,
                        input logic [3:0] oc);
      ent_t       o;
      logic [7:0]  etw;
      logic [39:0] etr;
      logic [3:0]  eoc;
      while (hist[k].size() > dep_k[k]) void'(hist[k].pop_back());
      o   = stage(k, dep_k[k] - 1);
      etw = 8'd0;
      etr = 40'd0;
      eoc = 4'd0;
      for (int i = 0; i < dep_k[k]; i++) begin
         etw[i]          = stage(k, i).w;
         etr[i*5 +: 5]   = stage(k, i).rd;
         eoc             = eoc + {3'd0, stage(k, i).v};
      end
      check("out_valid", k, {63'd0, ov}, {63'd0, o.v});
      check("RegWrite_out", k, {63'd0, rw}, {63'd0, o.w});
      check("RdAddr_out", k, {59'd0, ra}, {59'd0, o.rd});
      check("ALU_result_out", k, {32'd0, ar}, {32'd0, o.res});
      check("tap_wr", k, {56'd0, tw}, {56'd0, etw});
      check("tap_rd", k, {24'd0, tr}, {24'd0, etr});
      check("occupancy", k, {60'd0, oc}, {60'd0, eoc});
      check("wr_implies_valid", k, {63'd0, rw & ~ov}, 64'd0);
   endtask

   // Monitor: compare every DUT against the model away from the active edge.
   always @(negedge clk) begin
      if (armed) begin
         score(0, bus0.out_valid, bus0.RegWrite_out, bus0.RdAddr_out, bus0.ALU_result_out,
               {6'd0, bus0.tap_wr}, {30'd0, bus0.tap_rd}, bus0.occupancy);
         score(1, bus1.out_valid, bus1.RegWrite_out, bus1.RdAddr_out, bus1.ALU_result_out,
               {6'd0, bus1.tap_wr}, {30'd0, bus1.tap_rd}, bus1.occupancy);
         score(2, bus2.out_valid, bus2.RegWrite_out, bus2.RdAddr_out, bus2.ALU_result_out,
               {4'd0, bus2.tap_wr}, {20'd0, bus2.tap_rd}, bus2.occupancy);
      end
   end

   initial begin
      logic [4:0] rr;
      // Reset while a live entry is presented: must not be captured.
      step(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 5'd7, 32'hDEAD_BEEF);
      @(negedge clk);
      check("reset_out_valid", 0, {63'd0, bus0.out_valid}, 64'd0);
      check("reset_occupancy", 2, {60'd0, bus2.occupancy}, 64'd0);

      // Back-to-back entries rd=1..5.
      for (int i = 1; i <= 5; i++) step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 5'(i), 32'(i * 16));

      // Stall with rd=3,4 in flight while inputs change to rd=9.
      step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd3, 32'h33);
      step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd4, 32'h44);
      for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd9, 32'h99);
      @(negedge clk);
      check("stall_tap_rd", 0, {54'd0, bus0.tap_rd}, {54'd0, 5'd3, 5'd4});
      for (int i = 0; i < 2; i++) step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd9, 32'h99);
      @(negedge clk);
      check("stall_release_rd", 0, {59'd0, bus0.RdAddr_out}, 64'd9);

      // Flush together with stall: valids/writes drop, addresses stay.
      step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd7, 32'h77);
      step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd6, 32'h66);
      step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 5'd8, 32'h88);
      @(negedge clk);
      check("flush_rd_held", 0, {59'd0, bus0.RdAddr_out}, 64'd7);
      check("flush_tap_wr", 0, {62'd0, bus0.tap_wr}, 64'd0);

      // Write to $0 followed by bubbles.
      step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd0, 32'h1234);
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
      @(negedge clk);
      check("zero_guard_on", 0, {63'd0, bus0.RegWrite_out}, 64'd0);
      check("zero_guard_off", 1, {63'd0, bus1.RegWrite_out}, 64'd1);

      // Valid, bubble, valid, bubble into the four-deep chain.
      step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd2, 32'h2);
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd11, 32'hB);
      step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd5, 32'h5);
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd12, 32'hC);
      @(negedge clk);
      check("bubble_tap_wr", 2, {60'd0, bus2.tap_wr}, 64'b1010);
      check("bubble_occupancy", 2, {60'd0, bus2.occupancy}, 64'd2);

      // Randomized traffic including occasional reset and flush.
      for (int n = 0; n < 600; n++) begin
         rr = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
         step(($urandom_range(0, 63) == 0), ($urandom_range(0, 4) == 0),
              ($urandom_range(0, 15) == 0), ($urandom_range(0, 3) != 0),
              ($urandom_range(0, 3) != 0), rr, $urandom);
      end
      @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
